prio_grant_reg: RTL and testbench
=================================

# prio_grant_reg

Parametrised, registered priority selector for N request channels, each carrying a W-bit code. On every rising clock edge it picks one active requester, by fixed priority or round-robin, and registers two outputs:
- a pulse output that returns to zero whenever there is no grant;
- a sticky output that holds the last granted code.

It sits between request-generating control logic and downstream registers that need either a per-cycle strobe value or a held last-winner value.

## Interface
Parameters:
- N, 4: number of request channels (N ≥ 2).
- W, 2: code width per channel (W ≥ 1).
- RR, 0: arbitration mode. 0 = fixed priority (channel 0 highest). 1 = round-robin.
- CW, 8: idle-counter width.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  request bits; req[i] = channel i requests.
- data  input  N*W  channel codes; channel i occupies data[i*W +: W].
- y  output  W  registered pulse value: granted channel's code this cycle, else 0.
- z  output  W  registered sticky value: code of the most recent grant.
- gnt  output  N  registered one-hot grant; all zero when there is no grant.
- valid  output  1  registered; 1 when a grant was issued at the last edge.
- idx  output  clog2(N)  registered index of the last granted channel (sticky).
- idle_cnt  output  CW  registered count of consecutive edges with req == 0; saturating.

## Operation
- Reset (asynchronous, takes effect immediately, independent of clk): y=0, z=0, gnt=0, valid=0, idx=0, idle_cnt=0, internal round-robin pointer ptr=0.
- Each edge with req == 0:
  - y ← 0, gnt ← 0, valid ← 0.
  - z and idx hold.
  - idle_cnt ← idle_cnt+1, saturating at 2^CW−1.
- Each edge with req ≠ 0:
  - Winner w is selected as below.
  - gnt ← one-hot(w), valid ← 1, idx ← w.
  - y ← data[w], z ← data[w].
  - idle_cnt ← 0.
- Fixed mode (RR=0):
  - w = lowest index i with req[i]=1.
  - ptr is unused and stays 0.
- Round-robin mode (RR=1):
  - w = first i with req[i]=1, searching ptr, ptr+1, …, N−1, 0, …, ptr−1 (mod N).
  - After a grant, ptr ← (w+1) mod N. Wrap from N−1 to 0 is required.
  - ptr holds when there is no grant.
- Outputs never carry X or Z values once reset has been applied. y is fully defined (zero) on non-grant cycles.
- Codes are passed through unmodified. No arithmetic is applied to data.
- Simultaneous requests: exactly one grant per edge. gnt is never multi-hot.
- A requester that stays asserted is not latched. Each edge re-evaluates req from scratch.
- Only idle_cnt is arithmetic: CW-bit, increments by 1, holds at all-ones, never wraps.

## Timing
- Latency is 1 cycle: req/data sampled at edge k appear on y/z/gnt/valid/idx after edge k.
- There is no combinational path from inputs to outputs.
- y and valid are single-cycle wide per grant edge. Back-to-back grants produce back-to-back pulses.
- Reset asserted mid-operation clears all outputs and ptr asynchronously. The first grant after reset release follows ptr=0 ordering.
- The first edge after release with req == 0 drives idle_cnt to 1.

## Test plan
- Reset check: assert rst between edges → all outputs 0 immediately, without a clock edge. Release, drive req=0 for 3 edges → idle_cnt=3, y=0, z=0, valid=0.
- Fixed priority (N=4, W=2, RR=0): req=4'b1010, data={2'b11,2'b10,2'b01,2'b00} (ch3…ch0) → gnt=4'b0010, idx=1, y=z=2'b01, valid=1. Next edge req=0 → y=0, z stays 2'b01, idle_cnt=1.
- Round-robin (RR=1): req=4'b1111 held for 5 edges → gnt sequence 0001, 0010, 0100, 1000, 0001, exercising the wrap.
- Round-robin skip: from ptr=2, req=4'b0011 → gnt=4'b0001, then ptr=1. Next edge with the same req → gnt=4'b0010.
- Saturation (CW=3): req=0 for 10 edges → idle_cnt reaches 7 and holds at 7. One request then clears it to 0.
- Reset mid-stream (RR=1): after grant to ch2, assert rst → ptr=0. After release, req=4'b0101 → gnt=4'b0001.

Source files
------------

// File: rtl/prio_grant_reg_if.sv
`default_nettype none
// ============================================================================
// Module   : prio_grant_reg_if
// Purpose  : Request/code inputs and registered grant outputs of prio_grant_reg
// Revision : 1.0
// ============================================================================
interface prio_grant_reg_if #(
  parameter int N  = 4,
  parameter int W  = 2,
  parameter int CW = 8
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   req;
  logic [N*W-1:0] data;
  logic [W-1:0]   y;
  logic [W-1:0]   z;
  logic [N-1:0]   gnt;
  logic           valid;
  logic [IW-1:0]  idx;
  logic [CW-1:0]  idle_cnt;

  modport master (
    output req, data,
    input  y, z, gnt, valid, idx, idle_cnt
  );

  modport slave (
    input  req, data,
    output y, z, gnt, valid, idx, idle_cnt
  );
endinterface
`default_nettype wire

// File: rtl/prio_grant_reg.sv
`default_nettype none
// ============================================================================
// Module   : prio_grant_reg
// Purpose  : Registered fixed-priority / round-robin selector with pulse and
//            sticky code outputs plus a saturating idle counter
// Revision : 1.0
// ============================================================================
module prio_grant_reg #(
  parameter int N  = 4,
  parameter int W  = 2,
  parameter int RR = 0,
  parameter int CW = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  prio_grant_reg_if.slave        bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0]  w_codes [N];
  logic [IW-1:0] w_ptr;
  logic [IW-1:0] w_win;
  logic          w_found;
  logic [IW-1:0] w_cand;
  int            w_sum;

  logic [W-1:0]  y_q, y_d;
  logic [W-1:0]  z_q, z_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic          valid_q, valid_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] idle_q, idle_d;

  generate
    for (genvar g = 0; g < N; g++) begin : g_unpack
      assign w_codes[g] = bus.data[g*W +: W];
    end
  endgenerate

  // Circular search starting at w_ptr; in fixed mode w_ptr is tied to 0.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = 0;
    w_cand  = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = int'(w_ptr) + k;
      if (w_sum >= N) w_sum = w_sum - N;
      w_cand = w_sum[IW-1:0];
      if (!w_found && bus.req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  generate
    if (RR != 0) begin : g_rr
      logic [IW-1:0] ptr_q, ptr_d;

      always_comb begin
        ptr_d = ptr_q;
        if (w_found) begin
          ptr_d = (w_win == IW'(N-1)) ? '0 : w_win + IW'(1);
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
      end

      assign w_ptr = ptr_q;
    end else begin : g_fixed
      assign w_ptr = '0;
    end
  endgenerate

  always_comb begin
    y_d     = '0;
    z_d     = z_q;
    gnt_d   = '0;
    valid_d = 1'b0;
    idx_d   = idx_q;
    idle_d  = (idle_q == '1) ? idle_q : idle_q + CW'(1);
    if (w_found) begin
      y_d     = w_codes[w_win];
      z_d     = w_codes[w_win];
      gnt_d   = {{(N-1){1'b0}}, 1'b1} << w_win;
      valid_d = 1'b1;
      idx_d   = w_win;
      idle_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q     <= '0;
      z_q     <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      idle_q  <= '0;
    end else begin
      y_q     <= y_d;
      z_q     <= z_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      idle_q  <= idle_d;
    end
  end

  assign bus.y        = y_q;
  assign bus.z        = z_q;
  assign bus.gnt      = gnt_q;
  assign bus.valid    = valid_q;
  assign bus.idx      = idx_q;
  assign bus.idle_cnt = idle_q;
endmodule
`default_nettype wire

// File: tb/tb_prio_grant_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_prio_grant_reg
// Purpose  : Scoreboard bench for a fixed-priority (CW=3) and a round-robin
//            (CW=8) prio_grant_reg against a behavioural model
// Revision : 1.0
// ============================================================================
module tb_prio_grant_reg;
  localparam int N  = 4;
  localparam int W  = 2;
  localparam int IW = 2;

  typedef struct packed {
    logic [W-1:0]  y;
    logic [W-1:0]  z;
    logic [N-1:0]  gnt;
    logic          valid;
    logic [IW-1:0] idx;
    logic [7:0]    idle;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prio_grant_reg_if #(.N(N), .W(W), .CW(3)) bus_a ();
  prio_grant_reg_if #(.N(N), .W(W), .CW(8)) bus_b ();

  prio_grant_reg #(.N(N), .W(W), .RR(0), .CW(3)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  prio_grant_reg #(.N(N), .W(W), .RR(1), .CW(8)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int checks = 0;
  int errors = 0;

  exp_t qa[$];
  exp_t qb[$];

  // Model state per instance: index 0 = fixed/CW=3, index 1 = round-robin/CW=8
  int m_z[2], m_idx[2], m_idle[2], m_ptr[2];
  int m_max[2] = '{7, 255};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_z[d] = 0; m_idx[d] = 0; m_idle[d] = 0; m_ptr[d] = 0;
    end
  endtask

  task automatic model(input int d, input logic [N-1:0] r, input logic [N*W-1:0] dt, output exp_t e);
    int win;
    int code;
    win = -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr[d] + k) % N;
      if (win < 0 && r[i[IW-1:0]]) win = i;
    end
    e = '0;
    if (win < 0) begin
      if (m_idle[d] < m_max[d]) m_idle[d] = m_idle[d] + 1;
    end else begin
      code = int'((dt >> (win * W)) & ((1 << W) - 1));
      m_z[d]    = code;
      m_idx[d]  = win;
      m_idle[d] = 0;
      if (d == 1) m_ptr[d] = (win + 1) % N;
      e.y     = code[W-1:0];
      e.gnt   = N'(1 << win);
      e.valid = 1'b1;
    end
    e.z    = m_z[d][W-1:0];
    e.idx  = m_idx[d][IW-1:0];
    e.idle = m_idle[d][7:0];
  endtask

  task automatic step(input logic [N-1:0] r, input logic [N*W-1:0] dt);
    exp_t ea, eb;
    @(negedge clk);
    bus_a.req = r; bus_a.data = dt;
    bus_b.req = r; bus_b.data = dt;
    model(0, r, dt, ea);
    model(1, r, dt, eb);
    qa.push_back(ea);
    qb.push_back(eb);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_a_y"},     32'(bus_a.y), 0);
    chk({tag, "_a_z"},     32'(bus_a.z), 0);
    chk({tag, "_a_gnt"},   32'(bus_a.gnt), 0);
    chk({tag, "_a_valid"}, 32'(bus_a.valid), 0);
    chk({tag, "_a_idx"},   32'(bus_a.idx), 0);
    chk({tag, "_a_idle"},  32'(bus_a.idle_cnt), 0);
    chk({tag, "_b_y"},     32'(bus_b.y), 0);
    chk({tag, "_b_z"},     32'(bus_b.z), 0);
    chk({tag, "_b_gnt"},   32'(bus_b.gnt), 0);
    chk({tag, "_b_valid"}, 32'(bus_b.valid), 0);
    chk({tag, "_b_idx"},   32'(bus_b.idx), 0);
    chk({tag, "_b_idle"},  32'(bus_b.idle_cnt), 0);
  endtask

  // Asserts reset between edges, after the monitor has consumed the last entry.
  task automatic do_reset(input string tag);
    @(posedge clk);
    #3;
    rst = 1'b1;
    bus_a.req = '0; bus_b.req = '0;
    #1;
    check_zero(tag);
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  // Monitor: each edge that has a pending expectation is compared one cycle later.
  always @(posedge clk) begin
    exp_t ea, eb;
    #1;
    if (qa.size() > 0) begin
      ea = qa.pop_front();
      eb = qb.pop_front();
      chk("a_y",     32'(bus_a.y),        32'(ea.y));
      chk("a_z",     32'(bus_a.z),        32'(ea.z));
      chk("a_gnt",   32'(bus_a.gnt),      32'(ea.gnt));
      chk("a_valid", 32'(bus_a.valid),    32'(ea.valid));
      chk("a_idx",   32'(bus_a.idx),      32'(ea.idx));
      chk("a_idle",  32'(bus_a.idle_cnt), 32'(ea.idle));
      chk("b_y",     32'(bus_b.y),        32'(eb.y));
      chk("b_z",     32'(bus_b.z),        32'(eb.z));
      chk("b_gnt",   32'(bus_b.gnt),      32'(eb.gnt));
      chk("b_valid", 32'(bus_b.valid),    32'(eb.valid));
      chk("b_idx",   32'(bus_b.idx),      32'(eb.idx));
      chk("b_idle",  32'(bus_b.idle_cnt), 32'(eb.idle));
    end
  end

  initial begin
    logic [N*W-1:0] dconst;
    logic [N-1:0]   r;
    dconst = 8'b11_10_01_00;
    bus_a.req = '0; bus_a.data = '0;
    bus_b.req = '0; bus_b.data = '0;
    model_reset();

    do_reset("rst_init");
    repeat (3) step(4'b0000, dconst);

    step(4'b1010, dconst);
    step(4'b0000, dconst);

    repeat (5) step(4'b1111, dconst);

    step(4'b0010, dconst);
    repeat (2) step(4'b0011, dconst);

    repeat (10) step(4'b0000, dconst);
    step(4'b0001, dconst);

    step(4'b0100, dconst);
    do_reset("rst_mid");
    step(4'b0101, dconst);
    step(4'b0101, dconst);

    for (int n = 0; n < 300; n++) begin
      r = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      step(r, (N*W)'($urandom));
    end

    for (int t = 0; t < 10 && qa.size() > 0; t++) @(posedge clk);
    #3;
    checks++;
    if (qa.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", qa.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
